data_mem_dp: RTL and testbench
==============================

# data_mem_dp

Dual-port (one write, one read) data memory with a registered read port and a built-in initialisation sequencer. After reset, the sequencer zero-fills the whole array and then writes the preload constants. Only after that does the memory accept traffic. It sits between the core's load/store datapath and the register file, and replaces the single-pointer, combinational-read data memory.

## Interface
- W, 8, data width in bits (≥ 8).
- A, 8, address width; depth = 2**A.
- PRELOAD_BASE, 128, address of the first preload constant; must satisfy PRELOAD_BASE + 2 ≤ 2**A − 1.

- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Clear  in  1  synchronous request to re-run initialisation.
- Ready  out  1  high when the memory accepts reads and writes.
- WriteEn  in  1  write strobe.
- WriteAddr  in  A  write address.
- DataIn  in  W  write data.
- ReadEn  in  1  read strobe.
- ReadAddr  in  A  read address.
- DataOut  out  W  registered read data.
- DataValid  out  1  one-cycle pulse: DataOut holds the result of a read accepted on the previous edge.

## Operation
- States:
  - INIT_CLR: writes 0 to address cnt; cnt counts 0 → 2**A − 1.
  - INIT_PRE: 3 cycles; writes PRE0/PRE1/PRE2 to PRELOAD_BASE + 0/1/2.
  - RUN: normal traffic.
- Transitions:
  - INIT_CLR → INIT_PRE on the edge that writes address 2**A − 1.
  - INIT_PRE → RUN after the third preload write.
  - RUN → INIT_CLR on any edge with Clear = 1.
  - Clear is ignored during INIT_CLR and INIT_PRE.
- Reset (async assert) drives: state = INIT_CLR, cnt = 0, Ready = 0, DataOut = 0, DataValid = 0.
  - The array contents are not reset; the sequencer overwrites them.
- Reset mid-init or mid-RUN: the sequence restarts from address 0. A partial array state is never visible, because Ready stays 0.
- Ready = 1 only in RUN. It is registered, so it rises on the edge that enters RUN.
- Writes: on an edge with Ready = 1 and WriteEn = 1, core[WriteAddr] ← DataIn. With Ready = 0, WriteEn is dropped silently (no queuing).
- Reads: on an edge with Ready = 1 and ReadEn = 1, DataOut ← core[ReadAddr] and DataValid ← 1. Otherwise DataValid ← 0 and DataOut holds its previous value.
- Read and write to the same address on the same edge: write-first, so DataOut ← DataIn.
- Read and write to different addresses on the same edge: both complete independently.
- A Clear edge in RUN also performs any read/write presented on that edge; Ready drops on the same edge.
- Preload values are zero-extended to W bits.

## Timing
- Read latency is 1 cycle: address sampled on edge n, DataOut/DataValid valid after edge n; DataValid drops after edge n+1 unless a new read is accepted.
- Write-to-read latency is 1 cycle: a write on edge n is visible to a read accepted on edge n+1. A read on edge n itself sees the write via write-first forwarding.
- Initialisation length is exactly 2**A + 3 edges from Reset deassertion (or from the Clear edge) to Ready = 1. With A = 8 this is 259 edges.
- Throughput: one read and one write per cycle, no stalls in RUN.

## Structure
- Package data_mem_pkg:
  - state enum {INIT_CLR, INIT_PRE, RUN}.
  - Constants PRE0 = 8'h01, PRE1 = 8'hFF, PRE2 = 8'h40 (64).
- One sub-module, data_mem_init_seq. It holds the FSM and cnt, and outputs:
  - init write enable, init address, init data;
  - Ready.
- The top level muxes the init write port against the user write port (init wins; the user port is gated by Ready) and holds the array plus the registered read.
- Elaboration-time assertion on the PRELOAD_BASE range.

## Test plan
- Reset deassert; count edges to Ready = 1 → exactly 259 (A = 8). Then read 0, 127, 128, 129, 130, 255 → 0x00, 0x00, 0x01, 0xFF, 0x40, 0x00, each with DataValid one cycle later.
- In RUN, write 0x5A to address 10 and read address 10 on the same edge → DataOut = 0x5A, DataValid = 1. Read address 10 next edge → 0x5A.
- During INIT_CLR, assert WriteEn (addr 3, data 0x77) and ReadEn → DataValid stays 0. After Ready, read address 3 → 0x00.
- In RUN, write 0x11 to address 129, then pulse Clear → Ready falls the same edge and rises 259 edges later. Read address 129 → 0xFF.
- Assert Reset asynchronously mid-INIT_PRE (between edges) → Ready = 0, DataOut = 0, DataValid = 0 immediately. After deassertion, full 259-edge init completes.
- Back-to-back reads of 128, 129, 130 on consecutive edges with writes to 200, 201 → DataValid high 3 consecutive cycles with 0x01, 0xFF, 0x40. Later reads of 200/201 return the written data.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and preload constants for the data memory and its init sequencer.
package data_mem_pkg;

    typedef enum logic [1:0] {
        INIT_CLR,
        INIT_PRE,
        RUN
    } state_t;

    localparam logic [7:0] PRE0 = 8'h01;
    localparam logic [7:0] PRE1 = 8'hFF;
    localparam logic [7:0] PRE2 = 8'h40;

    function automatic logic [7:0] preload_value(input logic [1:0] idx);
        case (idx)
            2'd0:    preload_value = PRE0;
            2'd1:    preload_value = PRE1;
            default: preload_value = PRE2;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_init_seq.sv
// Initialisation sequencer: zero-fills the array, writes the preload constants,
// then raises Ready until a Clear restarts the sequence.
module data_mem_init_seq
    import data_mem_pkg::*;
#(
    parameter int W            = 8,
    parameter int A            = 8,
    parameter int PRELOAD_BASE = 128
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    output logic         InitWe,
    output logic [A-1:0] InitAddr,
    output logic [W-1:0] InitData,
    output logic         Ready
);

    state_t         state, state_nxt;
    logic [A-1:0]   cnt, cnt_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= INIT_CLR;
            cnt   <= '0;
            Ready <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Ready <= (state_nxt == RUN);
        end
    end

    // cnt walks the whole array in INIT_CLR, then indexes the preload constants.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        InitWe    = 1'b0;
        InitAddr  = cnt;
        InitData  = '0;
        case (state)
            INIT_CLR: begin
                InitWe = 1'b1;
                if (cnt == '1) begin
                    state_nxt = INIT_PRE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            INIT_PRE: begin
                InitWe   = 1'b1;
                InitAddr = A'(PRELOAD_BASE) + cnt;
                InitData = W'(preload_value(cnt[1:0]));
                if (cnt == A'(2)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                if (Clear) begin
                    state_nxt = INIT_CLR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = INIT_CLR;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_dp.sv
// One-write/one-read data memory with registered, write-first read port;
// the init sequencer owns the write port until Ready.
module data_mem_dp
    import data_mem_pkg::*;
#(
    parameter int W            = 8,
    parameter int A            = 8,
    parameter int PRELOAD_BASE = 128
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Clear,
    output logic         Ready,
    input  logic         WriteEn,
    input  logic [A-1:0] WriteAddr,
    input  logic [W-1:0] DataIn,
    input  logic         ReadEn,
    input  logic [A-1:0] ReadAddr,
    output logic [W-1:0] DataOut,
    output logic         DataValid
);

    localparam int DEPTH = 2 ** A;

    if (PRELOAD_BASE + 2 > DEPTH - 1) begin : g_bad_preload_base
        $error("data_mem_dp: PRELOAD_BASE + 2 must not exceed 2**A - 1");
    end
    if (W < 8) begin : g_bad_width
        $error("data_mem_dp: W must be at least 8");
    end

    logic [W-1:0] core [DEPTH];

    logic         init_we;
    logic [A-1:0] init_addr;
    logic [W-1:0] init_data;

    data_mem_init_seq #(
        .W            (W),
        .A            (A),
        .PRELOAD_BASE (PRELOAD_BASE)
    ) u_init_seq (
        .Clk      (Clk),
        .Reset    (Reset),
        .Clear    (Clear),
        .InitWe   (init_we),
        .InitAddr (init_addr),
        .InitData (init_data),
        .Ready    (Ready)
    );

    logic         user_we;
    logic         rd_fire;
    logic         mem_we;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_data;

    assign user_we  = Ready & WriteEn;
    assign rd_fire  = Ready & ReadEn;
    assign mem_we   = init_we | user_we;
    assign mem_addr = init_we ? init_addr : WriteAddr;
    assign mem_data = init_we ? init_data : DataIn;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            core[mem_addr] <= mem_data;
        end
    end

    // Read stage: same-address write on this edge is forwarded (write-first).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            DataOut   <= '0;
            DataValid <= 1'b0;
        end else begin
            DataValid <= rd_fire;
            if (rd_fire) begin
                DataOut <= (user_we && (WriteAddr == ReadAddr)) ? DataIn : core[ReadAddr];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_dp.sv
// Randomised self-checking bench for data_mem_dp against a behavioural memory model.
module tb_data_mem_dp;

    localparam int INIT_EDGES = 259;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Clear = 1'b0;
    logic       Ready;
    logic       WriteEn = 1'b0;
    logic [7:0] WriteAddr = '0;
    logic [7:0] DataIn = '0;
    logic       ReadEn = 1'b0;
    logic [7:0] ReadAddr = '0;
    logic [7:0] DataOut;
    logic       DataValid;

    always #5 Clk = ~Clk;

    data_mem_dp #(.W(8), .A(8), .PRELOAD_BASE(128)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Clear     (Clear),
        .Ready     (Ready),
        .WriteEn   (WriteEn),
        .WriteAddr (WriteAddr),
        .DataIn    (DataIn),
        .ReadEn    (ReadEn),
        .ReadAddr  (ReadAddr),
        .DataOut   (DataOut),
        .DataValid (DataValid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: memory contents, edges left until ready, expected read outputs.
    logic [7:0] mdl [256];
    int         init_left = INIT_EDGES;
    logic [7:0] exp_dout  = '0;
    logic       exp_vld   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_fill();
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        mdl[128] = 8'h01;
        mdl[129] = 8'hFF;
        mdl[130] = 8'h40;
    endfunction

    task automatic step(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic re, input logic [7:0] ra, input logic clr);
        WriteEn = we; WriteAddr = wa; DataIn = wd;
        ReadEn = re; ReadAddr = ra; Clear = clr;
        @(posedge Clk);
        #1;
        if (init_left == 0) begin
            exp_vld = re;
            if (re) exp_dout = (we && wa == ra) ? wd : mdl[ra];
            if (we) mdl[wa] = wd;
            if (clr) init_left = INIT_EDGES;
        end else begin
            exp_vld = 1'b0;
            init_left--;
            if (init_left == 0) model_fill();
        end
        check_eq("ready", Ready, init_left == 0);
        check_eq("valid", DataValid, exp_vld);
        check_eq("dout", DataOut, exp_dout);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rd(input logic [7:0] ra);
        step(1'b0, 8'h00, 8'h00, 1'b1, ra, 1'b0);
    endtask

    task automatic do_reset();
        WriteEn = 1'b0; ReadEn = 1'b0; Clear = 1'b0;
        Reset = 1'b1;
        #2;
        check_eq("rst_ready", Ready, 1'b0);
        check_eq("rst_dout", DataOut, 8'h00);
        check_eq("rst_valid", DataValid, 1'b0);
        exp_dout  = '0;
        exp_vld   = 1'b0;
        init_left = INIT_EDGES;
        #1;
        Reset = 1'b0;
    endtask

    task automatic wait_ready(input int expected);
        int n = 0;
        while (!Ready && n < 400) begin
            idle(1);
            n++;
        end
        check_eq("init_len", n, expected);
    endtask

    logic [7:0] da, db;

    initial begin
        // Power-up reset and first initialisation
        do_reset();
        wait_ready(INIT_EDGES);
        rd(8'd0);   check_eq("rd0", DataOut, 8'h00);
        rd(8'd127); check_eq("rd127", DataOut, 8'h00);
        rd(8'd128); check_eq("rd128", DataOut, 8'h01);
        rd(8'd129); check_eq("rd129", DataOut, 8'hFF);
        rd(8'd130); check_eq("rd130", DataOut, 8'h40);
        rd(8'd255); check_eq("rd255", DataOut, 8'h00);
        idle(1);    check_eq("valid_drop", DataValid, 1'b0);

        // Same-address read/write forwarding
        step(1'b1, 8'd10, 8'h5A, 1'b1, 8'd10, 1'b0);
        check_eq("fwd", DataOut, 8'h5A);
        check_eq("fwd_valid", DataValid, 1'b1);
        rd(8'd10);  check_eq("rd10", DataOut, 8'h5A);

        // Back-to-back reads with writes elsewhere
        da = 8'($urandom);
        db = 8'($urandom);
        step(1'b1, 8'd200, da, 1'b1, 8'd128, 1'b0); check_eq("b2b0", DataOut, 8'h01);
        step(1'b1, 8'd201, db, 1'b1, 8'd129, 1'b0); check_eq("b2b1", DataOut, 8'hFF);
        rd(8'd130); check_eq("b2b2", DataOut, 8'h40);
        rd(8'd200); check_eq("rd200", DataOut, da);
        rd(8'd201); check_eq("rd201", DataOut, db);

        // Clear re-runs the init and wipes user data
        step(1'b1, 8'd129, 8'h11, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        check_eq("clr_ready", Ready, 1'b0);
        wait_ready(INIT_EDGES);
        rd(8'd129); check_eq("clr_rd129", DataOut, 8'hFF);

        // Async reset in the middle of the preload phase
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        idle(257);
        do_reset();
        wait_ready(INIT_EDGES);
        rd(8'd129); check_eq("rst_rd129", DataOut, 8'hFF);

        // Traffic and Clear during init are dropped
        do_reset();
        idle(10);
        for (int i = 0; i < 20; i++) step(1'b1, 8'd3, 8'h77, 1'b1, 8'd3, 1'(i % 2));
        wait_ready(INIT_EDGES - 30);
        rd(8'd3);   check_eq("rd3", DataOut, 8'h00);

        // Random traffic, narrow address window to force collisions
        for (int i = 0; i < 600; i++) begin
            logic [7:0] wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) ra = wa;
            step(1'($urandom), wa, 8'($urandom), 1'($urandom), ra, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
